// File: rtl/cfg_loader.sv
// rtl/cfg_loader.sv - configuration-chain loader: word stream in, MSB-first serial CRAM chain out
module cfg_loader #(
    parameter int CHAIN_LEN = 48,
    parameter int WORD_W    = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              config_en,
    output logic              config_data_out,
    output logic              busy,
    output logic              done
);
    localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int REM    = CHAIN_LEN - (NWORDS - 1) * WORD_W;
    localparam int WCNT_W = $clog2(WORD_W + 1);
    localparam int BCNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WACC_W = $clog2(NWORDS + 1);

    localparam logic [WCNT_W-1:0] WCNT_FULL = WCNT_W'(WORD_W);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(REM);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(CHAIN_LEN - 1);
    localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);
    localparam logic [WACC_W-1:0] WACC_LAST = WACC_W'(NWORDS - 1);
    localparam logic [WACC_W-1:0] WACC_MAX  = WACC_W'(NWORDS);
    localparam logic [WACC_W-1:0] WACC_ONE  = WACC_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [WORD_W-1:0]   sreg;
    logic [WCNT_W-1:0]   wcnt;
    logic [BCNT_W-1:0]   bitcnt;
    logic [WACC_W-1:0]   wacc;
    logic                cfg_en_q;
    logic                cfg_data_q;
    logic                done_q;
    logic                shift;
    logic                last_bit;
    logic                accept;

    assign shift    = (state == S_LOAD) && (wcnt != '0);
    assign last_bit = shift && (bitcnt == BCNT_LAST);
    assign accept   = word_valid && word_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (en) begin
            if (abort) begin
                state_nxt = S_IDLE;
            end else begin
                case (state)
                    S_IDLE:  if (start) state_nxt = S_LOAD;
                    S_LOAD:  if (last_bit) state_nxt = S_DONE;
                    S_DONE:  state_nxt = S_IDLE;
                    default: state_nxt = S_IDLE;
                endcase
            end
        end
    end

    // The chain sees enable/done only while en is high; registered copies freeze with the rest.
    always_comb begin
        busy            = (state == S_LOAD);
        word_ready      = en && (state == S_LOAD) && (wcnt <= WCNT_ONE) && (wacc < WACC_MAX);
        config_en       = cfg_en_q && en;
        config_data_out = cfg_data_q;
        done            = done_q && en;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sreg       <= '0;
            wcnt       <= '0;
            bitcnt     <= '0;
            wacc       <= '0;
            cfg_en_q   <= 1'b0;
            cfg_data_q <= 1'b0;
            done_q     <= 1'b0;
        end else if (en) begin
            if (abort) begin
                cfg_en_q <= 1'b0;
                done_q   <= 1'b0;
                wcnt     <= '0;
            end else begin
                cfg_en_q <= shift;
                done_q   <= (state == S_DONE);
                if ((state == S_IDLE) && start) begin
                    sreg   <= '0;
                    wcnt   <= '0;
                    bitcnt <= '0;
                    wacc   <= '0;
                end
                if (shift) begin
                    cfg_data_q <= sreg[WORD_W-1];
                    sreg       <= {sreg[WORD_W-2:0], 1'b0};
                    wcnt       <= wcnt - WCNT_ONE;
                    bitcnt     <= bitcnt + BCNT_ONE;
                end
                // A word accepted on the last-bit cycle replaces sreg after that bit leaves: no bubble.
                if (accept) begin
                    sreg <= word_in;
                    wcnt <= (wacc == WACC_LAST) ? WCNT_LAST : WCNT_FULL;
                    wacc <= wacc + WACC_ONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_cfg_loader.sv
// tb/tb_cfg_loader.sv - randomized self-checking bench for cfg_loader against a bit-queue model
module tb_cfg_loader;
    localparam int CL  = 48;
    localparam int WW  = 8;
    localparam int NW  = (CL + WW - 1) / WW;
    localparam int REM = CL - (NW - 1) * WW;
    localparam int CLB = 20;

    logic          clk        = 1'b0;
    logic          nrst       = 1'b0;
    logic          en         = 1'b1;
    logic          start      = 1'b0;
    logic          abort      = 1'b0;
    logic          word_valid = 1'b0;
    logic [WW-1:0] word_in    = '0;
    logic          word_ready, config_en, config_data_out, busy, done;

    logic          start_b      = 1'b0;
    logic          word_valid_b = 1'b0;
    logic [WW-1:0] word_in_b    = '0;
    logic          word_ready_b, config_en_b, config_data_out_b, busy_b, done_b;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    cfg_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) u_dut (
        .clk(clk), .nrst(nrst), .en(en), .start(start), .abort(abort),
        .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
        .config_en(config_en), .config_data_out(config_data_out), .busy(busy), .done(done)
    );

    cfg_loader #(.CHAIN_LEN(CLB), .WORD_W(WW)) u_dut_b (
        .clk(clk), .nrst(nrst), .en(1'b1), .start(start_b), .abort(1'b0),
        .word_in(word_in_b), .word_valid(word_valid_b), .word_ready(word_ready_b),
        .config_en(config_en_b), .config_data_out(config_data_out_b), .busy(busy_b), .done(done_b)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkv(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pending chain bits live in a queue; one leaves per enabled LOAD cycle.
    typedef enum int {M_IDLE, M_LOAD, M_DONE} mst_t;
    mst_t          m_st   = M_IDLE;
    bit            bitq[$];
    int            m_acc  = 0;
    int            m_shift = 0;
    bit            m_cen  = 1'b0;
    bit            m_dat  = 1'b0;
    bit            m_done = 1'b0;
    logic [WW-1:0] ws [NW];
    logic [WW-1:0] ws_b [3];

    function automatic bit m_ready();
        return (en === 1'b1) && (m_st == M_LOAD) && (bitq.size() <= 1) && (m_acc < NW);
    endfunction

    always begin : model
        bit acc;
        int nb;
        @(posedge clk or negedge nrst);
        if (!nrst) begin
            m_st = M_IDLE; bitq.delete(); m_acc = 0; m_shift = 0; m_cen = 0; m_done = 0;
        end else if (en) begin
            acc = m_ready() && (word_valid === 1'b1);
            if (abort) begin
                m_st = M_IDLE; m_cen = 0; m_done = 0; bitq.delete();
            end else begin
                m_cen = 0;
                m_done = 0;
                case (m_st)
                    M_IDLE: if (start) begin
                        m_st = M_LOAD; m_acc = 0; m_shift = 0; bitq.delete();
                    end
                    M_LOAD: begin
                        if (bitq.size() > 0) begin
                            m_cen = 1; m_dat = bitq.pop_front(); m_shift++;
                            if (m_shift == CL) m_st = M_DONE;
                        end
                        if (acc) begin
                            nb = (m_acc == NW - 1) ? REM : WW;
                            for (int i = 0; i < nb; i++) bitq.push_back(word_in[WW-1-i]);
                            m_acc++;
                        end
                    end
                    default: begin
                        m_done = 1; m_st = M_IDLE;
                    end
                endcase
            end
        end
    end

    function automatic logic [63:0] golden();
        logic [63:0] g;
        g = '0;
        for (int i = 0; i < CL; i++) g[CL-1-i] = ws[i/WW][WW-1-(i%WW)];
        return g;
    endfunction

    always @(negedge clk) word_in = ws[(m_acc < NW) ? m_acc : NW - 1];

    int          cyc = 0, mon_cen = 0, mon_done = 0, mon_hs = 0;
    int          first_cen = -1, last_cen = -1, start_cyc = -1, done_cyc = -1;
    logic [63:0] coll = '0;
    int          hs_b = 0, cen_b = 0, done_b_cnt = 0;
    logic [63:0] coll_b = '0;

    always @(negedge clk) word_in_b = ws_b[(hs_b < 3) ? hs_b : 2];

    always begin : compare
        @(negedge clk);
        #1;
        cyc++;
        check1("config_en", config_en, en & m_cen);
        if (m_cen && en) check1("config_data_out", config_data_out, m_dat);
        check1("done", done, en & m_done);
        check1("busy", busy, m_st == M_LOAD);
        check1("word_ready", word_ready, m_ready());
        if (config_en) begin
            coll = {coll[62:0], config_data_out};
            mon_cen++;
            if (first_cen < 0) first_cen = cyc;
            last_cen = cyc;
        end
        if (done) begin mon_done++; done_cyc = cyc; end
        if (word_valid && word_ready) mon_hs++;
        if (start && en && start_cyc < 0) start_cyc = cyc;
        if (config_en_b) begin coll_b = {coll_b[62:0], config_data_out_b}; cen_b++; end
        if (done_b) done_b_cnt++;
        if (word_valid_b && word_ready_b) hs_b++;
    end

    task automatic mon_clear();
        coll = '0; mon_cen = 0; mon_done = 0; mon_hs = 0;
        first_cen = -1; last_cen = -1; start_cyc = -1; done_cyc = -1;
    endtask

    task automatic run_load(input int vpct, input int en_off_at, input bit t3_gap,
                            input int abort_at, input bit hold_start);
        int  gap_left;
        bit  gapped;
        int  k;
        gap_left = 0;
        gapped   = 0;
        @(negedge clk);
        mon_clear();
        start = 1'b1;
        en = 1'b1;
        word_valid = ($urandom_range(99) < vpct);
        for (k = 0; k < 600; k++) begin
            @(negedge clk);
            start = (hold_start && k < 10) || (k == abort_at);
            en    = !(en_off_at >= 0 && k >= en_off_at && k < en_off_at + 3);
            abort = (k == abort_at);
            if (t3_gap && !gapped && m_acc == 2 && m_ready()) begin
                gap_left = 5;
                gapped = 1;
            end
            if (gap_left > 0) begin
                word_valid = 1'b0;
                gap_left--;
            end else begin
                word_valid = ($urandom_range(99) < vpct);
            end
            #2;
            if (abort_at >= 0 && k == abort_at + 1) check1("abort_idle", busy, 1'b0);
            if (abort_at < 0 && mon_done > 0) break;
            if (abort_at >= 0 && k > abort_at + 4) break;
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0; en = 1'b1; word_valid = 1'b0;
        #2;
        if (abort_at < 0) begin
            checkv("stream", coll, golden());
            checkn("cen_count", mon_cen, CL);
            checkn("done_count", mon_done, 1);
        end else begin
            checkn("abort_no_done", mon_done, 0);
        end
    endtask

    initial begin
        ws = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E};
        ws_b = '{8'hF0, 8'h0F, 8'hAB};
        repeat (3) @(negedge clk);
        #2;
        check1("rst_config_en", config_en, 1'b0);
        check1("rst_data", config_data_out, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_ready", word_ready, 1'b0);
        check1("rst_done", done, 1'b0);
        @(negedge clk);
        nrst = 1'b1;

        // continuous valid: fixed latency, back-to-back bits, six handshakes
        run_load(100, -1, 0, -1, 0);
        checkv("t1_stream", coll, 64'h0000_A53C_FF00_817E);
        checkn("t1_hs", mon_hs, 6);
        checkn("t1_first_lat", first_cen - start_cyc, 3);
        checkn("t1_span", last_cen - first_cen, 47);
        checkn("t1_done_lat", done_cyc - last_cen, 1);

        // valid gap right when the third word is wanted
        run_load(100, -1, 1, -1, 0);
        checkv("t3_stream", coll, 64'h0000_A53C_FF00_817E);
        checkn("t3_span", last_cen - first_cen, 52);

        // en low for three cycles mid-word
        run_load(100, 12, 0, -1, 0);
        checkv("t4_stream", coll, 64'h0000_A53C_FF00_817E);

        // abort mid-load with start asserted alongside, start held during load
        run_load(100, -1, 0, 15, 1);

        // asynchronous reset between edges, then a full reload
        @(negedge clk);
        start = 1'b1; word_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (18) @(negedge clk);
        #3 nrst = 1'b0;
        #1;
        check1("arst_config_en", config_en, 1'b0);
        check1("arst_data", config_data_out, 1'b0);
        check1("arst_busy", busy, 1'b0);
        check1("arst_ready", word_ready, 1'b0);
        check1("arst_done", done, 1'b0);
        @(negedge clk);
        nrst = 1'b1; word_valid = 1'b0;
        run_load(100, -1, 0, -1, 0);
        checkv("t5_stream", coll, 64'h0000_A53C_FF00_817E);

        // short chain: remainder word truncated to its top four bits
        @(negedge clk);
        coll_b = '0; cen_b = 0; done_b_cnt = 0; hs_b = 0;
        start_b = 1'b1; word_valid_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int k = 0; k < 200 && done_b_cnt == 0; k++) @(negedge clk);
        word_valid_b = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        checkn("t2_hs", hs_b, 3);
        checkn("t2_cen", cen_b, CLB);
        checkn("t2_done", done_b_cnt, 1);
        checkv("t2_stream", coll_b, 64'h0000_0000_000F_00FA);
        checkv("t2_tail", {60'h0, coll_b[3:0]}, 64'h0000_0000_0000_000A);

        // randomized loads
        for (int r = 0; r < 10; r++) begin
            foreach (ws[i]) ws[i] = WW'($urandom);
            run_load($urandom_range(100, 30),
                     (r % 3 == 0) ? int'($urandom_range(30, 5)) : -1,
                     0,
                     (r == 5 || r == 8) ? 20 : -1,
                     r[0]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #400000;
        n_err++;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
